// File: rtl/dvi_timing_pkg.sv
// Shared definitions for the DVI timing generator: counter limits, run-state encoding,
// the bundle of sync bits carried through the pixel-fetch delay line, and VESA presets.
package dvi_timing_pkg;

    localparam int MAX_TOTAL    = 4096;
    localparam int MAX_PIPE_LAT = 7;
    localparam int CNT_W        = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } run_state_e;

    // Everything that must stay cycle-aligned with the pixel data returned by upstream.
    typedef struct packed {
        logic first;
        logic vs;
        logic hs;
        logic de;
    } sync_bits_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } timing_t;

    localparam timing_t TIMING_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol: 1'b0,  vs_pol: 1'b0
    };

    localparam timing_t TIMING_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1,  vs_pol: 1'b1
    };

    function automatic bit fits_counter(input int total);
        return (total >= 1) && (total <= MAX_TOTAL);
    endfunction

endpackage

// File: rtl/dvi_delay_line.sv
// Fixed-depth shift register with a programmable reset pattern; DEPTH of zero is a wire.
module dvi_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator: walks h/v counters, requests pixels from upstream and
// re-times sync/enable through a delay line so they line up with the returned pixel data.
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE   = TIMING_800X600_60.h_active,
    parameter int H_FP       = TIMING_800X600_60.h_fp,
    parameter int H_SYNC     = TIMING_800X600_60.h_sync,
    parameter int H_BP       = TIMING_800X600_60.h_bp,
    parameter int V_ACTIVE   = TIMING_800X600_60.v_active,
    parameter int V_FP       = TIMING_800X600_60.v_fp,
    parameter int V_SYNC     = TIMING_800X600_60.v_sync,
    parameter int V_BP       = TIMING_800X600_60.v_bp,
    parameter bit HS_POL     = TIMING_800X600_60.hs_pol,
    parameter bit VS_POL     = TIMING_800X600_60.vs_pol,
    parameter int PIPE_LAT   = 2,
    parameter int COLOR_BITS = 4,
    parameter int FRAME_W    = 16
) (
    input  logic                    clk_dot,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic                    pix_req,
    output logic [11:0]             pix_x,
    output logic [11:0]             pix_y,
    input  logic [23:0]             pix_rgb,
    output logic                    vid_de,
    output logic                    vid_hs,
    output logic                    vid_vs,
    output logic [3*COLOR_BITS-1:0] vid_rgb,
    output logic                    frame_start,
    output logic [FRAME_W-1:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!fits_counter(H_TOTAL) || !fits_counter(V_TOTAL)) begin : g_bad_total
        $error("dvi_timing_gen: H_TOTAL and V_TOTAL must lie in 1..4096");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > MAX_PIPE_LAT) begin : g_bad_lat
        $error("dvi_timing_gen: PIPE_LAT must lie in 0..7");
    end
    if (COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_bad_color
        $error("dvi_timing_gen: COLOR_BITS must lie in 1..8");
    end

    // One extra bit so window ends equal to 4096 still compare correctly.
    localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bits_t RAW_IDLE = '{first: 1'b0, vs: ~VS_POL, hs: ~HS_POL, de: 1'b0};

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [CNT_W:0]   h_ext, v_ext;
    logic             counting;
    logic             at_last;

    assign h_ext    = {1'b0, h_q};
    assign v_ext    = {1'b0, v_q};
    assign counting = (state_q != ST_IDLE);
    assign at_last  = (h_ext == H_LAST) && (v_ext == V_LAST);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        if (counting) begin
            if (h_ext == H_LAST) begin
                h_d = '0;
                v_d = (v_ext == V_LAST) ? '0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = ST_RUN;
            end
            // Dropping enable on the very last pixel finishes the frame at once rather
            // than draining a whole extra frame.
            ST_RUN: begin
                if (!enable) state_d = at_last ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable)       state_d = ST_RUN;
                else if (at_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    sync_bits_t raw;
    sync_bits_t dly;

    always_comb begin
        raw = RAW_IDLE;
        if (counting) begin
            raw.de    = (h_ext < H_ACT) && (v_ext < V_ACT);
            raw.hs    = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
            raw.vs    = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
            raw.first = (h_q == '0) && (v_q == '0);
        end
    end

    assign pix_req = raw.de;
    assign pix_x   = h_q;
    assign pix_y   = v_q;

    dvi_delay_line #(
        .WIDTH   ($bits(sync_bits_t)),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (RAW_IDLE)
    ) u_delay (
        .clk   (clk_dot),
        .rst_n (reset_n),
        .din   (raw),
        .dout  (dly)
    );

    logic                    vid_de_q, vid_de_d;
    logic                    vid_hs_q, vid_hs_d;
    logic                    vid_vs_q, vid_vs_d;
    logic [3*COLOR_BITS-1:0] vid_rgb_q, vid_rgb_d;
    logic                    frame_start_q, frame_start_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;

    // Only the channel MSBs reach the output; the remaining input bits are intentionally dropped.
    logic unused_rgb_bits;
    assign unused_rgb_bits = ^pix_rgb;

    always_comb begin
        vid_de_d      = dly.de;
        vid_hs_d      = dly.hs;
        vid_vs_d      = dly.vs;
        vid_rgb_d     = '0;
        frame_start_d = dly.first;
        frame_cnt_d   = frame_cnt_q;
        if (dly.de) begin
            vid_rgb_d = {pix_rgb[23 -: COLOR_BITS],
                         pix_rgb[15 -: COLOR_BITS],
                         pix_rgb[7  -: COLOR_BITS]};
        end
        if (dly.first) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            vid_de_q      <= 1'b0;
            vid_hs_q      <= ~HS_POL;
            vid_vs_q      <= ~VS_POL;
            vid_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            vid_de_q      <= vid_de_d;
            vid_hs_q      <= vid_hs_d;
            vid_vs_q      <= vid_vs_d;
            vid_rgb_q     <= vid_rgb_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vid_de      = vid_de_q;
    assign vid_hs      = vid_hs_q;
    assign vid_vs      = vid_vs_q;
    assign vid_rgb     = vid_rgb_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen on a 16x8 raster: a per-cycle reference model feeds an expected
// queue that a negedge monitor drains, followed by directed checks on the logged outputs.
module tb_dvi_timing_gen;

    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b1;
    localparam int PIPE_LAT = 2;
    localparam int CB = 4;
    localparam int FW = 2;
    localparam int MAXC = 4096;

    typedef struct packed {
        int          cyc;
        logic        req;
        logic [11:0] px;
        logic [11:0] py;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        fs;
        logic [1:0]  fcnt;
    } exp_t;

    typedef struct packed {
        bit de;
        bit hs;
        bit vs;
        bit first;
    } raw_t;

    logic          clk_dot = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          pix_req;
    logic [11:0]   pix_x, pix_y;
    logic [23:0]   pix_rgb;
    logic          vid_de, vid_hs, vid_vs;
    logic [11:0]   vid_rgb;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;

    dvi_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL),
        .PIPE_LAT(PIPE_LAT), .COLOR_BITS(CB), .FRAME_W(FW)
    ) dut (
        .clk_dot     (clk_dot),
        .reset_n     (reset_n),
        .enable      (enable),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .vid_de      (vid_de),
        .vid_hs      (vid_hs),
        .vid_vs      (vid_vs),
        .vid_rgb     (vid_rgb),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_dot = ~clk_dot;

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_print = 0;
    int   cyc     = 0;

    logic        log_req [MAXC];
    logic        log_de  [MAXC];
    logic        log_hs  [MAXC];
    logic        log_vs  [MAXC];
    logic        log_fs  [MAXC];
    logic [1:0]  log_fcnt[MAXC];
    logic [11:0] log_rgb [MAXC];

    // ---------------- reference model ----------------
    bit   m_active;
    int   m_pos;
    raw_t hist[PIPE_LAT];
    exp_t vid_exp;

    function automatic raw_t raw_of(input bit act, input int p);
        raw_t r;
        int   hh, vv;
        hh = p % HT;
        vv = p / HT;
        r.de    = act && (hh < HA) && (vv < VA);
        r.hs    = act && (hh >= HA + HFP) && (hh < HA + HFP + HSW);
        r.vs    = act && (vv >= VA + VFP) && (vv < VA + VFP + VSW);
        r.first = act && (p == 0);
        return r;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        for (int i = 0; i < PIPE_LAT; i++) hist[i] = '0;
        vid_exp     = '0;
        vid_exp.hs  = ~HS_POL;
        vid_exp.vs  = ~VS_POL;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic en, input logic [23:0] rgb);
        raw_t cur;
        raw_t old;
        exp_t e;
        @(posedge clk_dot);
        #1;
        reset_n = r;
        enable  = en;
        pix_rgb = rgb;
        if (!r) model_reset();
        cur   = raw_of(m_active, m_pos);
        e     = vid_exp;
        e.cyc = cyc;
        e.req = cur.de;
        e.px  = 12'(m_pos % HT);
        e.py  = 12'(m_pos / HT);
        exp_q.push_back(e);
        if (r) begin
            old         = hist[PIPE_LAT-1];
            vid_exp.de  = old.de;
            vid_exp.hs  = old.hs ? HS_POL : ~HS_POL;
            vid_exp.vs  = old.vs ? VS_POL : ~VS_POL;
            vid_exp.fs  = old.first;
            vid_exp.rgb = old.de ? {rgb[23:20], rgb[15:12], rgb[7:4]} : 12'h000;
            if (old.first) vid_exp.fcnt = vid_exp.fcnt + 2'd1;
            for (int i = PIPE_LAT-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
            if (m_active) begin
                if (m_pos == FT-1 && !en) m_active = 1'b0;
                m_pos = (m_pos + 1) % FT;
            end else if (en) begin
                m_active = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic en, input bit rnd_rgb);
        logic [23:0] rgb;
        for (int i = 0; i < n; i++) begin
            rgb = rnd_rgb ? 24'($urandom) : 24'hF0A05F;
            step(1'b1, en, rgb);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk_dot);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{cyc: e.cyc, req: pix_req, px: pix_x, py: pix_y, de: vid_de, hs: vid_hs,
                      vs: vid_vs, rgb: vid_rgb, fs: frame_start, fcnt: frame_cnt};
                if (e.cyc < MAXC) begin
                    log_req[e.cyc]  = pix_req;
                    log_de[e.cyc]   = vid_de;
                    log_hs[e.cyc]   = vid_hs;
                    log_vs[e.cyc]   = vid_vs;
                    log_fs[e.cyc]   = frame_start;
                    log_fcnt[e.cyc] = frame_cnt;
                    log_rgb[e.cyc]  = vid_rgb;
                end
                n_total++;
                if (a === e) begin
                    n_pass++;
                end else if (n_print < 40) begin
                    n_print++;
                    $display("FAIL cycle_%0d: got req=%b x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h fs=%b cnt=%0d, required req=%b x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h fs=%b cnt=%0d",
                             e.cyc, a.req, a.px, a.py, a.de, a.hs, a.vs, a.rgb, a.fs, a.fcnt,
                             e.req, e.px, e.py, e.de, e.hs, e.vs, e.rgb, e.fs, e.fcnt);
                end
            end
        end
    end

    // ---------------- log queries ----------------
    function automatic logic sig(input int kind, input int i);
        case (kind)
            0:       return log_req[i];
            1:       return log_de[i];
            2:       return log_hs[i];
            3:       return log_vs[i];
            default: return log_fs[i];
        endcase
    endfunction

    function automatic int first_hi(input int kind, input int from, input int to);
        for (int i = from; i < to; i++) if (sig(kind, i) === 1'b1) return i;
        return -1;
    endfunction

    function automatic int last_hi(input int kind, input int from, input int to);
        int l = -1;
        for (int i = from; i < to; i++) if (sig(kind, i) === 1'b1) l = i;
        return l;
    endfunction

    function automatic int count_hi(input int kind, input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) if (sig(kind, i) === 1'b1) n++;
        return n;
    endfunction

    // ---------------- stimulus and directed checks ----------------
    initial begin : main
        int c0, cr, c1, c1_end, c2, c2_end, fs_i;
        logic en;
        logic r;
        int fs_cyc[$];
        int exp_cnt[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

        reset_n = 1'b0;
        enable  = 1'b0;
        pix_rgb = '0;
        model_reset();
        vid_exp.fcnt = '0;
        vid_exp.fs   = 1'b0;

        repeat (3) step(1'b0, 1'b0, 24'h0);

        // Start-up timing with a constant pixel colour, then a mid-line reset.
        run(3, 1'b0, 1'b0);
        c0 = cyc;
        run(40, 1'b1, 1'b0);
        cr = cyc;
        step(1'b0, 1'b1, 24'hF0A05F);
        step(1'b0, 1'b0, 24'hF0A05F);

        // Enable dropped during line 2: the frame must still finish.
        run(2, 1'b0, 1'b1);
        c1 = cyc;
        run(35, 1'b1, 1'b1);
        run(250, 1'b0, 1'b1);
        c1_end = cyc;

        // Long run with a short enable glitch mid-frame.
        step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        run(1, 1'b0, 1'b1);
        c2 = cyc;
        run(704, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        run(384, 1'b1, 1'b1);
        c2_end = cyc;

        // Random enable / reset / pixel data.
        en = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            r = ($urandom_range(0, 299) != 0);
            step(r, en, 24'($urandom));
        end
        run(4, 1'b0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_dot);
        #1;
        check("queue_drained", exp_q.size(), 0);

        check("req_first",   first_hi(0, c0, c0 + 17), c0 + 1);
        check("req_count",   count_hi(0, c0, c0 + 17), 8);
        check("de_first",    first_hi(1, c0, c0 + 17), c0 + 4);
        check("de_last",     last_hi(1, c0, c0 + 17),  c0 + 11);
        check("hs_first",    first_hi(2, c0, c0 + 20), c0 + 14);
        check("hs_count",    count_hi(2, c0, c0 + 20), 3);
        check("fs_first",    first_hi(4, c0, cr),      c0 + 4);
        check("fs_count_a",  count_hi(4, c0, cr),      1);
        check("rgb_active",  int'(log_rgb[c0 + 4]),    12'hFA5);
        check("rgb_line1",   int'(log_rgb[c0 + 20]),   12'hFA5);
        check("rgb_blank",   int'(log_rgb[c0 + 12]),   12'h000);

        check("pre_rst_cnt", int'(log_fcnt[cr - 1]),   1);
        check("pre_rst_de",  int'(log_de[cr - 1]),     1);
        check("rst_de",      int'(log_de[cr]),         0);
        check("rst_hs",      int'(log_hs[cr]),         0);
        check("rst_vs",      int'(log_vs[cr]),         0);
        check("rst_rgb",     int'(log_rgb[cr]),        0);
        check("rst_cnt",     int'(log_fcnt[cr]),       0);

        check("drain_fs_count", count_hi(4, c1, c1_end), 1);
        check("drain_cnt",      int'(log_fcnt[c1_end - 1]), 1);
        check("drain_req_count", count_hi(0, c1, c1_end), VA * HA);
        check("drain_req_last", last_hi(0, c1, c1_end), c1 + 56);
        check("drain_vs_last",  last_hi(3, c1, c1_end), c1 + 115);

        for (int i = c2; i < c2_end; i++) if (log_fs[i] === 1'b1) fs_cyc.push_back(i);
        check("run_fs_count", fs_cyc.size(), 9);
        fs_i = 0;
        foreach (fs_cyc[k]) begin
            if (k < 9) begin
                check($sformatf("fs_cycle_%0d", k), fs_cyc[k], c2 + 4 + FT * k);
                check($sformatf("fs_cnt_%0d", k), int'(log_fcnt[fs_cyc[k]]), exp_cnt[k]);
                fs_i++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch, cycles
- H_SYNC, 128, hsync width, cycles
- H_BP, 88, horizontal back porch, cycles
- V_ACTIVE, 600, active lines
- V_FP, 1, vertical front porch, lines
- V_SYNC, 4, vsync width, lines
- V_BP, 23, vertical back porch, lines
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- PIPE_LAT, 2, cycles from pix_req to pix_rgb valid (0..7)
- COLOR_BITS, 4, output bits per channel (1..8)
- FRAME_W, 16, frame counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_dot, in, 1, pixel clock; sole clock
- reset_n, in, 1, asynchronous, active-low reset
- enable, in, 1, run request
- pix_req, out, 1, upstream pixel fetch strobe
- pix_x, out, 12, fetch column
- pix_y, out, 12, fetch row
- pix_rgb, in, 24, {r,g,b} 8b each, valid PIPE_LAT cycles after pix_req
- vid_de, out, 1, data enable
- vid_hs, out, 1, hsync
- vid_vs, out, 1, vsync
- vid_rgb, out, 3*COLOR_BITS, {r,g,b} pixel
- frame_start, out, 1, one-cycle pulse on first output pixel of frame
- frame_cnt, out, FRAME_W, completed-frame-start count

Function
REQ-003 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL advance each cycle in RUN/DRAIN; h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1 (H_TOTAL/V_TOTAL = sum of four respective params).
REQ-004 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 4096 or PIPE_LAT exceeds 7.
REQ-005 pix_req SHALL be high, combinationally from registered counters, iff h<H_ACTIVE and v<V_ACTIVE in RUN/DRAIN; pix_x=h, pix_y=v.
REQ-006 Raw hs SHALL be active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; raw vs for the equivalent v window (full lines); inactive level is the complement of the _POL parameter.
REQ-007 de, hs, vs and frame-start SHALL pass through a PIPE_LAT-stage delay line plus one output register, so vid_* lag counters by PIPE_LAT+1 cycles and align with registered pix_rgb.
REQ-008 vid_rgb SHALL register the COLOR_BITS MSBs of each channel of pix_rgb when the delayed de is high, else all zero.
REQ-009 State machine: IDLE -> RUN when enable=1 (counting from h=v=0 next cycle); RUN -> DRAIN when enable=0; DRAIN -> RUN if enable=1 again; DRAIN -> IDLE after h=H_TOTAL-1,v=V_TOTAL-1; IDLE holds h=v=0.
REQ-010 In IDLE counters SHALL not advance and raw de=0, hs/vs inactive; the delay line keeps shifting so in-flight values drain out.
REQ-011 frame_start SHALL pulse when the delayed first-pixel marker (h=0,v=0 in RUN/DRAIN) exits the pipeline; frame_cnt SHALL increment on that cycle, wrapping modulo 2^FRAME_W.

Reset
REQ-012 reset_n low SHALL asynchronously force: IDLE, h=v=0, delay line cleared to inactive, vid_de=0, vid_hs=~HS_POL, vid_vs=~VS_POL, vid_rgb=0, frame_start=0, frame_cnt=0.
REQ-013 Reset assertion mid-frame SHALL abort the frame; after release, operation restarts from IDLE per REQ-009.

Structure
REQ-014 Shared package dvi_timing_pkg SHALL hold timing presets (640x480@60, 800x600@60) and the 4096 limit constant.
REQ-015 The delay line SHALL be sub-module dvi_delay_line (parametrised width and depth, async active-low reset).

Verification (H 8/2/3/3=16, V 4/1/2/1=8, PIPE_LAT=2, COLOR_BITS=4)
REQ-016 Reset: reset_n=0 mid-line -> next edge vid_de=0, vid_hs=0, vid_vs=0, vid_rgb=0, frame_cnt=0.
REQ-017 enable=1 at cycle 0 -> pix_req cycles 1..8, vid_de cycles 4..11, vid_hs cycles 14..16, frame_start cycle 4.
REQ-018 pix_rgb=24'hF0A05F during active -> vid_rgb=12'hFA5; blanking -> 12'h000.
REQ-019 enable dropped at line 2 -> frame completes (128 counter cycles from start), no further frame_start, frame_cnt=1.
REQ-020 FRAME_W=2, enable held 5 frames -> frame_cnt 1,2,3,0,1.
REQ-021 enable toggled 1-0-1 within one frame -> no stall, frame period stays 128 cycles.
